// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, prefetches into a small buffer, hands off over valid/ready.
// Optional out-of-range fetch fault enabled by FETCH_BOUNDS_CHECK_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 256,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        busy
`ifdef FETCH_BOUNDS_CHECK_EN
  ,
  output logic        fault
`endif
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0] PC_INIT = RESET_PC & ~32'h3;

  if (DEPTH < 2 || DEPTH > 8 || MEM_WORDS == 0) begin : g_bad_param
    $error("fetch_sequencer: DEPTH must be 2..8 and MEM_WORDS non-zero");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
`ifdef FETCH_BOUNDS_CHECK_EN
    ,
    S_FAULT  = 2'd3
`endif
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  entry_t           buf_q [DEPTH];
  entry_t           buf_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      instr_pc_q, instr_pc_d;
  logic             valid_q, busy_q;
  logic             pop, push, flush;
  logic [CNT_W-1:0] kept;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [32:0] PC_LIMIT = 33'(MEM_WORDS) << 2;
  logic fault_q;
  logic oob;
  assign oob = {1'b0, pc_q} >= PC_LIMIT;
`endif

  // Next-state, PC and buffer update; redirect outranks everything but FAULT.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    count_d    = count_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    pop        = valid_q && instr_ready;
    push       = 1'b0;
    flush      = 1'b0;
    kept       = count_q;

`ifdef FETCH_BOUNDS_CHECK_EN
    if (state_q == S_FAULT) begin
      pop   = 1'b0;
      flush = 1'b1;
    end else
`endif
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_pc & ~32'h3;
      state_d = halt ? S_HALTED : S_FETCH;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED: begin
          if (start && !halt) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (halt) state_d = S_HALTED;
`ifdef FETCH_BOUNDS_CHECK_EN
          else if (oob) begin
            state_d = S_FAULT;
            flush   = 1'b1;
          end
`endif
          else push = (count_q < DEPTH_C) || pop;
        end
        default: ;
      endcase
    end

    if (flush) begin
      count_d = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) buf_d[i] = buf_q[i+1];
      end
      kept = count_q - CNT_W'(pop);
      if (push) begin
        buf_d[kept] = '{pc: pc_q, data: imem_rdata};
        pc_d        = pc_q + 32'd4;
      end
      count_d = kept + CNT_W'(push);
    end

    // Head registers hold their last value whenever the buffer goes empty.
    if (count_d != '0) begin
      instr_d    = buf_d[0].data;
      instr_pc_d = buf_d[0].pc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_INIT;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      buf_q      <= buf_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= (count_d != '0);
      busy_q     <= (state_d == S_FETCH);
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q    <= (state_d == S_FAULT);
`endif
    end
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign busy        = busy_q;
`ifdef FETCH_BOUNDS_CHECK_EN
  assign fault       = fault_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected PCs queued at stimulus, checked on each handshake.
module tb_fetch_sequencer;

  localparam int unsigned DEPTH = 2;
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam int unsigned MEMW = 4;
`else
  localparam int unsigned MEMW = 256;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        busy;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic        fault;
`endif

  int total = 0;
  int bad = 0;
  int pops_seen = 0;
  logic [31:0] exp_q[$];

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .MEM_WORDS(MEMW),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .halt          (halt),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .busy          (busy)
`ifdef FETCH_BOUNDS_CHECK_EN
    ,
    .fault         (fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'hDEAD_0000 ^ ((addr >> 2) * 32'h0101_0101);
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // Handshake monitor; a pop coinciding with a redirect is cancelled by the flush.
  always @(negedge clk) begin
    logic [31:0] e;
    if (reset_n && instr_valid && instr_ready && !redirect_valid) begin
      pops_seen++;
      if (exp_q.size() == 0) begin
        check("sb_extra_pop", instr_pc, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", instr_pc, e);
        check("sb_instr", instr, mem_word(e));
      end
    end
  end

  initial begin
    tick();
    tick();
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);
    reset_n = 1'b1;

    // Streaming from reset with decode always ready
    push_range(32'h0, 4);
    instr_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("a_busy", 32'(busy), 32'd1);
    check("a_first_latency", 32'(instr_valid), 32'd0);
    tick();
    check("a_first_valid", 32'(instr_valid), 32'd1);
    check("a_first_pc", instr_pc, 32'h0);
    repeat (4) tick();
    instr_ready = 1'b0;
    check("a_queue_drained", 32'(exp_q.size()), 32'd0);
    check("a_pops", 32'(pops_seen), 32'd4);

`ifdef FETCH_BOUNDS_CHECK_EN
    check("f_fault", 32'(fault), 32'd1);
    check("f_valid", 32'(instr_valid), 32'd0);
    check("f_pc", imem_addr, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("f_redirect_ignored_fault", 32'(fault), 32'd1);
    check("f_redirect_ignored_pc", imem_addr, 32'h10);
    check("f_redirect_ignored_valid", 32'(instr_valid), 32'd0);
    #3;
`else
    #3;
    check("pre_rst_valid", 32'(instr_valid), 32'd1);
`endif

    // Asynchronous reset between edges
    reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_instr", instr, 32'h0);
    check("arst_instr_pc", instr_pc, 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_imem_addr", imem_addr, 32'h0);
`ifdef FETCH_BOUNDS_CHECK_EN
    check("arst_fault", 32'(fault), 32'd0);
`endif
    tick();
    reset_n = 1'b1;
    pops_seen = 0;

`ifndef FETCH_BOUNDS_CHECK_EN
    // Back-pressure fills the buffer and freezes the PC
    push_range(32'h0, 6);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("b_pc_frozen", imem_addr, 32'(DEPTH * 4));
    check("b_valid_held", 32'(instr_valid), 32'd1);
    check("b_pc_held", instr_pc, 32'h0);
    check("b_instr_held", instr, mem_word(32'h0));
    instr_ready = 1'b1;
    repeat (6) tick();
    instr_ready = 1'b0;
    check("b_queue_drained", 32'(exp_q.size()), 32'd0);
    check("b_pops", 32'(pops_seen), 32'd6);
    repeat (2) tick();

    // Redirect into a full buffer while a pop is offered
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0013;
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b0;
    check("c_flush_valid", 32'(instr_valid), 32'd0);
    check("c_target_pc", imem_addr, 32'h10);
    tick();
    check("c_target_valid", 32'(instr_valid), 32'd1);
    check("c_target_instr_pc", instr_pc, 32'h10);
    check("c_target_instr", instr, mem_word(32'h10));

    // Halt with two buffered entries at PC 8
    redirect_valid = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    check("d_pc8", imem_addr, 32'h8);
    check("d_head0", instr_pc, 32'h0);
    push_range(32'h0, 2);
    pops_seen = 0;
    halt = 1'b1;
    instr_ready = 1'b1;
    tick();
    halt = 1'b0;
    check("d_halted_busy", 32'(busy), 32'd0);
    repeat (2) tick();
    check("d_drained_valid", 32'(instr_valid), 32'd0);
    check("d_pc_kept", imem_addr, 32'h8);
    check("d_pops", 32'(pops_seen), 32'd2);
    halt = 1'b1;
    start = 1'b1;
    tick();
    halt = 1'b0;
    start = 1'b0;
    check("d_halt_wins_busy", 32'(busy), 32'd0);
    check("d_halt_wins_pc", imem_addr, 32'h8);
    push_range(32'h8, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("d_resume_busy", 32'(busy), 32'd1);
    tick();
    check("d_resume_pc", instr_pc, 32'h8);
    repeat (2) tick();
    instr_ready = 1'b0;
    check("d_queue_drained", 32'(exp_q.size()), 32'd0);
    check("d_total_pops", 32'(pops_seen), 32'd4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the CPU's combinational, word-addressed instruction memory (32-bit words; index = byte address >> 2).
- Owns the program counter and drives the memory address.
- Captures each returned word, with its PC, into a small prefetch buffer.
- Hands instructions to decode over a valid/ready handshake.
- Handles branch redirects (flush and reload) and halt/resume.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded at reset; low two bits ignored.
- MEM_WORDS, 256: instruction memory depth in words; used only by the bounds check.
- DEPTH, 2: prefetch buffer entries; allowed range 2–8.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin fetching, or resume after halt.
- halt  in  1  stop issuing new fetches; the buffer still drains.
- redirect_valid  in  1  branch taken or PC write.
- redirect_pc  in  32  new fetch address.
- imem_addr  out  32  byte address to instruction memory; always equals the PC.
- imem_rdata  in  32  instruction word; combinational from imem_addr.
- instr  out  32  instruction at the buffer head.
- instr_pc  out  32  byte address of instr.
- instr_valid  out  1  buffer non-empty.
- instr_ready  in  1  decode accepts instr.
- busy  out  1  high when state is FETCH.
- fault  out  1  fetch out of range; present only with the macro.

## Operation
States: IDLE, FETCH, HALTED, and FAULT (FAULT exists only with the macro).

Reset (asynchronous):
- state = IDLE, PC = RESET_PC & ~3, buffer empty.
- Outputs: instr_valid = 0, instr = 0, instr_pc = 0, busy = 0, fault = 0, imem_addr = RESET_PC & ~3.

Fetch and buffer:
- In FETCH, a push occurs when the buffer has space, or is full and a pop occurs in the same cycle.
- A push writes {PC, imem_rdata} into the buffer and advances PC by 4.
- PC wraps modulo 2^32.
- Pop: instr_valid && instr_ready. Pops are accepted in every state except FAULT.
- instr and instr_pc hold their values while instr_valid = 0.

Redirect (highest priority):
- Flushes the buffer, including any pop in the same cycle.
- Loads PC = redirect_pc & ~3. No push occurs that cycle.
- From IDLE, FETCH or HALTED, next state = HALTED if halt is high, else FETCH.

Halt and resume:
- halt in FETCH (without redirect) → HALTED. The PC is kept and no push occurs that cycle.
- start in IDLE or HALTED → FETCH.
- halt and start asserted together → halt wins.
- start while already in FETCH has no effect.

## Timing
- Memory is read in the same cycle. The first instruction after start is at edge N; instr_valid rises after edge N+1 with instr_pc = RESET_PC.
- Redirect at edge N: instr_valid = 0 after edge N, then the target instruction is valid after edge N+1.
- Throughput: 1 instruction/cycle sustained while instr_ready stays high.
- Back-pressure: instr, instr_pc and instr_valid stay stable while instr_ready = 0. PC stalls once the buffer holds DEPTH entries.
- After halt, buffered entries continue to drain at 1 per cycle.

## Configuration
- FETCH_BOUNDS_CHECK_EN defined:
  - A FETCH cycle with PC ≥ MEM_WORDS*4 does not push and moves to FAULT.
  - fault is registered high from the next cycle.
  - In FAULT the buffer is flushed, instr_valid = 0, and no pops occur.
  - Redirect and start are ignored in FAULT; only reset_n exits.
- FETCH_BOUNDS_CHECK_EN undefined:
  - The fault port and FAULT state are absent.
  - Out-of-range addresses are passed to memory unchanged.

## Test plan
- Reset, then start with instr_ready held 1: instr_pc sequence 0, 4, 8, 12 on consecutive cycles, with instr = mem[0..3].
- Hold instr_ready = 0 for 5 cycles after start: the buffer fills to DEPTH and imem_addr freezes at DEPTH*4. On release, pops return PCs 0, 4, ... with no gaps or duplicates.
- Redirect to 32'h0000_0013 while the buffer is full and a pop is occurring in the same cycle: next cycle instr_valid = 0; the cycle after, instr_pc = 32'h10.
- halt at PC = 8 with 2 entries buffered: exactly 2 further pops occur, then instr_valid = 0 and imem_addr holds 8. start resumes at 8. halt and start asserted together keep the state HALTED.
- reset_n asserted mid-stream, asynchronously between clock edges: outputs take their reset values immediately, with imem_addr = RESET_PC.
- With the macro and MEM_WORDS = 4, fetching from 0: PCs 0–12 are delivered, then fault = 1 and instr_valid = 0. Redirect to 0 has no effect; only reset_n clears fault.
